decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 142 ++++++++++++++
 tb/tb_decode_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: register file read with writeback bypass,
// busy scoreboard for RAW hazards, and a 1-deep output register.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int SEXT_OFF = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [AW-1:0]   dst,
  output logic [XLEN-1:0] src1,
  output logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] offset,
  output logic [NREG-1:0] busy
);

  logic [XLEN-1:0] r_rf [NREG];
  logic [NREG-1:0] r_busy;
  logic            r_valid;
  logic [6:0]      r_op;
  logic [AW-1:0]   r_dst;
  logic [XLEN-1:0] r_s1;
  logic [XLEN-1:0] r_s2;
  logic [XLEN-1:0] r_off;

  logic [AW-1:0]   w_dst;
  logic [AW-1:0]   w_a1;
  logic [AW-1:0]   w_a2;
  logic            w_wb;
  logic            w_hz1;
  logic            w_hz2;
  logic            w_acc;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_off;
  logic [NREG-1:0] w_busy_nx;

  assign w_dst = instruction[20 +: AW];
  assign w_a1  = instruction[15 +: AW];
  assign w_a2  = instruction[10 +: AW];
  assign w_wb  = wb_en && (wb_addr != '0);

  // A same-cycle writeback resolves the pending write
  assign w_hz1 = r_busy[w_a1]
              && !(wb_en && wb_addr == w_a1);
  assign w_hz2 = r_busy[w_a2]
              && !(wb_en && wb_addr == w_a2);

  assign in_ready = (!r_valid || out_ready)
                 && !(w_hz1 || w_hz2)
                 && !flush;
  assign w_acc = in_valid && in_ready;

  always_comb begin
    w_op1 = r_rf[w_a1];
    if (w_a1 == '0)
      w_op1 = '0;
    else if (wb_en && wb_addr == w_a1)
      w_op1 = wb_data;
  end

  always_comb begin
    w_op2 = r_rf[w_a2];
    if (w_a2 == '0)
      w_op2 = '0;
    else if (wb_en && wb_addr == w_a2)
      w_op2 = wb_data;
  end

  assign w_off = (SEXT_OFF != 0)
    ? XLEN'($signed(instruction[9:0]))
    : XLEN'(instruction[9:0]);

  // Set after clear so a new issue wins over a retiring write
  always_comb begin
    w_busy_nx = r_busy;
    if (w_wb)
      w_busy_nx[wb_addr] = 1'b0;
    if (w_acc && w_dst != '0)
      w_busy_nx[w_dst] = 1'b1;
    if (flush)
      w_busy_nx = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r_rf[i] <= '0;
    end else if (w_wb) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_busy <= '0;
    else
      r_busy <= w_busy_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_dst   <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_off   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_op    <= instruction[31:25];
      r_dst   <= w_dst;
      r_s1    <= w_op1;
      r_s2    <= w_op2;
      r_off   <= w_off;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign opcode    = r_op;
  assign dst       = r_dst;
  assign src1      = r_s1;
  assign src2      = r_s2;
  assign offset    = r_off;
  assign busy      = r_busy & ~NREG'(1);

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios then random
// traffic, checked against a behavioural register/scoreboard model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  opcode;
  logic [4:0]  dst;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] offset;
  logic [31:0] busy;

  logic        z_in_ready;
  logic        z_out_valid;
  logic [6:0]  z_opcode;
  logic [4:0]  z_dst;
  logic [31:0] z_src1;
  logic [31:0] z_src2;
  logic [31:0] z_offset;
  logic [31:0] z_busy;

  always #5 clk = ~clk;

  decode_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .dst(dst),
    .src1(src1), .src2(src2),
    .offset(offset), .busy(busy)
  );

  decode_stage #(.SEXT_OFF(0)) u_zext (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(z_in_ready),
    .instruction(instruction), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(z_out_valid), .out_ready(out_ready),
    .opcode(z_opcode), .dst(z_dst),
    .src1(z_src1), .src2(z_src2),
    .offset(z_offset), .busy(z_busy)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_busy;
  logic        m_ov;
  logic [6:0]  m_op;
  logic [4:0]  m_dst;
  logic [31:0] m_s1, m_s2, m_off, m_offz;
  logic        m_acc;
  logic        pre_ready;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_busy = '0; m_ov = 1'b0; m_op = '0; m_dst = '0;
    m_s1 = '0; m_s2 = '0; m_off = '0; m_offz = '0;
  endtask

  function automatic logic [31:0] mk(int op, int d,
      int a1, int a2, int off);
    logic [31:0] r;
    r = {op[6:0], d[4:0], a1[4:0], a2[4:0], off[9:0]};
    return r;
  endfunction

  task automatic check_outs(string tag);
    chk({tag, ".out_valid"}, out_valid, m_ov);
    chk({tag, ".opcode"}, opcode, m_op);
    chk({tag, ".dst"}, dst, m_dst);
    chk({tag, ".src1"}, src1, m_s1);
    chk({tag, ".src2"}, src2, m_s2);
    chk({tag, ".offset"}, offset, m_off);
    chk({tag, ".busy"}, busy, m_busy);
    chk({tag, ".zoffset"}, z_offset, m_offz);
    chk({tag, ".zvalid"}, z_out_valid, m_ov);
  endtask

  // One clock: drive, check readiness, then update the model
  task automatic cycle(input logic iv, input logic [31:0] ins,
      input logic fl, input logic we, input logic [4:0] wa,
      input logic [31:0] wd, input logic ordy);
    logic [4:0] d, a1, a2;
    logic hz, er;
    logic [31:0] v1, v2;
    in_valid = iv; instruction = ins; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    out_ready = ordy;
    #1;
    d = ins[24:20]; a1 = ins[19:15]; a2 = ins[14:10];
    hz = (m_busy[a1] && !(we && wa == a1))
      || (m_busy[a2] && !(we && wa == a2));
    er = (!m_ov || ordy) && !hz && !fl;
    pre_ready = in_ready;
    chk("in_ready", in_ready, er);
    m_acc = iv && er;
    v1 = (a1 == 0) ? 32'h0 : (we && wa == a1) ? wd : m_rf[a1];
    v2 = (a2 == 0) ? 32'h0 : (we && wa == a2) ? wd : m_rf[a2];
    @(posedge clk); #1;
    if (we && wa != 0) m_rf[wa] = wd;
    if (fl) begin
      m_ov = 1'b0;
      m_busy = '0;
    end else begin
      if (we && wa != 0) m_busy[wa] = 1'b0;
      if (m_acc) begin
        m_ov = 1'b1; m_op = ins[31:25]; m_dst = d;
        m_s1 = v1; m_s2 = v2;
        m_off = {{22{ins[9]}}, ins[9:0]};
        m_offz = {22'h0, ins[9:0]};
        if (d != 0) m_busy[d] = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
    end
    check_outs("cyc");
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; instruction = '0; flush = 0;
    wb_en = 0; wb_addr = '0; wb_data = '0; out_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_outs("reset");
    rst_n = 1'b1;

    // first edge after release accepts; also write r3
    cycle(1, mk(7'h11, 0, 0, 0, 5), 0, 1, 3, 32'h1234, 1);
    chk("first_accept", out_valid, 1);
    cycle(1, mk(7'h12, 0, 3, 0, 0), 0, 0, 0, 0, 1);
    chk("r3_read", src1, 32'h1234);
    chk("r3_valid", out_valid, 1);

    cycle(1, mk(7'h13, 0, 0, 5, 0), 0, 1, 5, 32'hAA, 1);
    chk("bypass_src2", src2, 32'hAA);
    cycle(0, '0, 0, 1, 0, 32'hFF, 1);
    cycle(1, mk(1, 0, 0, 0, 0), 0, 0, 0, 0, 1);
    chk("r0_zero", src1, 0);

    cycle(1, mk(2, 7, 0, 0, 0), 0, 0, 0, 0, 1);
    chk("busy_r7", busy, 32'h80);
    cycle(1, mk(3, 0, 7, 0, 0), 0, 0, 0, 0, 1);
    chk("hazard_stall1", pre_ready, 0);
    cycle(1, mk(3, 0, 7, 0, 0), 0, 0, 0, 0, 1);
    chk("hazard_stall2", pre_ready, 0);
    cycle(1, mk(3, 0, 7, 0, 0), 0, 1, 7, 32'h77, 1);
    chk("hazard_release", pre_ready, 1);
    chk("hazard_src1", src1, 32'h77);
    chk("hazard_busy", busy, 0);

    for (int i = 0; i < 3; i++) begin
      cycle(1, mk(4, 0, 0, 0, 10'h15), 0, 0, 0, 0, 0);
      chk("stall_ready", pre_ready, 0);
      chk("stall_opcode", opcode, 3);
      chk("stall_src1", src1, 32'h77);
      chk("stall_valid", out_valid, 1);
    end
    cycle(1, mk(4, 0, 0, 0, 10'h15), 0, 0, 0, 0, 1);
    chk("release_ready", pre_ready, 1);
    chk("release_opcode", opcode, 4);

    cycle(1, mk(5, 0, 0, 0, 10'h3FF), 0, 0, 0, 0, 1);
    chk("sext_off", offset, 32'hFFFF_FFFF);
    chk("zext_off", z_offset, 32'h0000_03FF);

    cycle(1, mk(6, 7, 0, 0, 0), 0, 0, 0, 0, 1);
    chk("pre_flush_busy", busy, 32'h80);
    cycle(1, mk(6, 0, 0, 0, 0), 1, 0, 0, 0, 0);
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);

    cycle(1, mk(8, 3, 3, 0, 1), 0, 0, 0, 0, 1);
    cycle(1, mk(9, 0, 0, 0, 0), 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    #1 rst_n = 1'b1;
    cycle(1, mk(1, 0, 3, 0, 0), 0, 0, 0, 0, 1);
    chk("rf_cleared", src1, 0);

    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0,
            mk($urandom_range(0, 127), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 1023)),
            $urandom_range(0, 31) == 0,
            $urandom_range(0, 1) != 0,
            5'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
